// File: rtl/pong_collision_scorer.sv
// Pong collision detector and scorer: evaluates registered ball samples against walls/paddles,
// emits one-cycle bounce/point pulses, and runs the serve / game-over sequencing.
module pong_collision_scorer #(
   parameter int COORD_W     = 6,
   parameter int FIELD_W     = 64,
   parameter int FIELD_H     = 64,
   parameter int PADDLE_H    = 8,
   parameter int LEFT_X      = 2,
   parameter int RIGHT_X     = 61,
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_DELAY = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pos_valid,
   input  logic [COORD_W-1:0] bx,
   input  logic [COORD_W-1:0] by,
   input  logic               bx_dir,
   input  logic               by_dir,
   input  logic [COORD_W-1:0] p1_y,
   input  logic [COORD_W-1:0] p2_y,
   input  logic               start,
   output logic               paddle_collision,
   output logic               wall_collision,
   output logic               point_scored,
   output logic               scorer,
   output logic [3:0]         sc1,
   output logic [3:0]         sc2,
   output logic               serve_hold,
   output logic               game_over
);
   localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
   localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(FIELD_W - 1);
   localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(FIELD_H - 1);
   localparam logic [COORD_W-1:0] LZ_LO   = COORD_W'(1);
   localparam logic [COORD_W-1:0] LZ_HI   = COORD_W'(LEFT_X + 1);
   localparam logic [COORD_W-1:0] RZ_LO   = COORD_W'(RIGHT_X - 1);
   localparam logic [COORD_W-1:0] RZ_HI   = COORD_W'(FIELD_W - 2);
   localparam logic [COORD_W:0]   PAD_SPAN = (COORD_W+1)'(PADDLE_H - 1);
   localparam logic [3:0]         WIN     = 4'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY - 1);

   typedef enum logic [1:0] {PLAY, SERVE_WAIT, GAME_OVER} state_t;

   // Input sample stage: the ball sample is captured first and evaluated on the next edge.
   logic               smp_valid_q, smp_bx_dir_q, smp_by_dir_q;
   logic [COORD_W-1:0] smp_bx_q, smp_by_q, smp_p1_q, smp_p2_q;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               left_armed_q, left_armed_d, right_armed_q, right_armed_d;
   logic               top_armed_q, top_armed_d, bot_armed_q, bot_armed_d;
   logic               pc_q, pc_d, wc_q, wc_d, ps_q, ps_d, scorer_q, scorer_d;
   logic [3:0]         sc1_q, sc1_d, sc2_q, sc2_d;
   logic               hold_q, hold_d, go_q, go_d;

   logic               active, miss_l, miss_r, in_p1, in_p2;
   logic               hit_l, hit_r, hit_t, hit_b;
   logic [COORD_W:0]   by_ext, p1_top, p2_top;

   // Paddle range is computed one bit wider so a paddle near the bottom does not wrap.
   always_comb begin
      by_ext = {1'b0, smp_by_q};
      p1_top = {1'b0, smp_p1_q};
      p2_top = {1'b0, smp_p2_q};
      in_p1  = (by_ext >= p1_top) && (by_ext <= p1_top + PAD_SPAN);
      in_p2  = (by_ext >= p2_top) && (by_ext <= p2_top + PAD_SPAN);
      active = smp_valid_q && (state_q == PLAY);
      miss_l = active && !smp_bx_dir_q && (smp_bx_q == '0);
      miss_r = active &&  smp_bx_dir_q && (smp_bx_q == X_MAX);
      hit_l  = active && !smp_bx_dir_q && (smp_bx_q >= LZ_LO) && (smp_bx_q <= LZ_HI)
               && in_p1 && left_armed_q;
      hit_r  = active &&  smp_bx_dir_q && (smp_bx_q >= RZ_LO) && (smp_bx_q <= RZ_HI)
               && in_p2 && right_armed_q;
      hit_t  = active && top_armed_q && !smp_by_dir_q && (smp_by_q == '0);
      hit_b  = active && bot_armed_q &&  smp_by_dir_q && (smp_by_q == Y_MAX);
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      left_armed_d  = left_armed_q;
      right_armed_d = right_armed_q;
      top_armed_d   = top_armed_q;
      bot_armed_d   = bot_armed_q;
      pc_d          = 1'b0;
      wc_d          = 1'b0;
      ps_d          = 1'b0;
      scorer_d      = scorer_q;
      sc1_d         = sc1_q;
      sc2_d         = sc2_q;
      case (state_q)
         PLAY: begin
            if (active) begin
               left_armed_d  = smp_bx_dir_q  ? 1'b1 : (hit_l ? 1'b0 : left_armed_q);
               right_armed_d = !smp_bx_dir_q ? 1'b1 : (hit_r ? 1'b0 : right_armed_q);
               top_armed_d   = smp_by_dir_q  ? 1'b1 : (hit_t ? 1'b0 : top_armed_q);
               bot_armed_d   = !smp_by_dir_q ? 1'b1 : (hit_b ? 1'b0 : bot_armed_q);
               if (miss_l || miss_r) begin
                  ps_d          = 1'b1;
                  scorer_d      = miss_l;
                  cnt_d         = '0;
                  left_armed_d  = 1'b1;
                  right_armed_d = 1'b1;
                  top_armed_d   = 1'b1;
                  bot_armed_d   = 1'b1;
                  if (miss_l) sc2_d = sc2_q + 4'd1;
                  else        sc1_d = sc1_q + 4'd1;
                  state_d = ((sc1_d == WIN) || (sc2_d == WIN)) ? GAME_OVER : SERVE_WAIT;
               end else begin
                  pc_d = hit_l || hit_r;
                  wc_d = hit_t || hit_b;
               end
            end
         end
         SERVE_WAIT: begin
            if (cnt_q == CNT_LAST) state_d = PLAY;
            else                   cnt_d   = cnt_q + CNT_W'(1);
         end
         GAME_OVER: begin
            if (start) begin
               state_d       = SERVE_WAIT;
               cnt_d         = '0;
               sc1_d         = '0;
               sc2_d         = '0;
               left_armed_d  = 1'b1;
               right_armed_d = 1'b1;
               top_armed_d   = 1'b1;
               bot_armed_d   = 1'b1;
            end
         end
         default: state_d = SERVE_WAIT;
      endcase
      hold_d = (state_d != PLAY);
      go_d   = (state_d == GAME_OVER);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         smp_valid_q   <= 1'b0;
         smp_bx_dir_q  <= 1'b0;
         smp_by_dir_q  <= 1'b0;
         smp_bx_q      <= '0;
         smp_by_q      <= '0;
         smp_p1_q      <= '0;
         smp_p2_q      <= '0;
         state_q       <= SERVE_WAIT;
         cnt_q         <= '0;
         left_armed_q  <= 1'b1;
         right_armed_q <= 1'b1;
         top_armed_q   <= 1'b1;
         bot_armed_q   <= 1'b1;
         pc_q          <= 1'b0;
         wc_q          <= 1'b0;
         ps_q          <= 1'b0;
         scorer_q      <= 1'b0;
         sc1_q         <= '0;
         sc2_q         <= '0;
         hold_q        <= 1'b1;
         go_q          <= 1'b0;
      end else begin
         smp_valid_q   <= pos_valid;
         smp_bx_dir_q  <= bx_dir;
         smp_by_dir_q  <= by_dir;
         smp_bx_q      <= bx;
         smp_by_q      <= by;
         smp_p1_q      <= p1_y;
         smp_p2_q      <= p2_y;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         left_armed_q  <= left_armed_d;
         right_armed_q <= right_armed_d;
         top_armed_q   <= top_armed_d;
         bot_armed_q   <= bot_armed_d;
         pc_q          <= pc_d;
         wc_q          <= wc_d;
         ps_q          <= ps_d;
         scorer_q      <= scorer_d;
         sc1_q         <= sc1_d;
         sc2_q         <= sc2_d;
         hold_q        <= hold_d;
         go_q          <= go_d;
      end
   end

   assign paddle_collision = pc_q;
   assign wall_collision   = wc_q;
   assign point_scored     = ps_q;
   assign scorer           = scorer_q;
   assign sc1              = sc1_q;
   assign sc2              = sc2_q;
   assign serve_hold       = hold_q;
   assign game_over        = go_q;
endmodule

// File: tb/tb_pong_collision_scorer.sv
// Directed bench for pong_collision_scorer: hand-computed vectors for bounces, arming, misses,
// serve timing, win/restart and asynchronous reset.
module tb_pong_collision_scorer;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pos_valid = 1'b0;
   logic [5:0] bx = '0, by = '0, p1_y = '0, p2_y = '0;
   logic       bx_dir = 1'b0, by_dir = 1'b0, start = 1'b0;
   logic       paddle_collision, wall_collision, point_scored, scorer, serve_hold, game_over;
   logic [3:0] sc1, sc2;

   int checks = 0;
   int errors = 0;

   pong_collision_scorer dut (
      .clk(clk), .reset(reset), .pos_valid(pos_valid), .bx(bx), .by(by),
      .bx_dir(bx_dir), .by_dir(by_dir), .p1_y(p1_y), .p2_y(p2_y), .start(start),
      .paddle_collision(paddle_collision), .wall_collision(wall_collision),
      .point_scored(point_scored), .scorer(scorer), .sc1(sc1), .sc2(sc2),
      .serve_hold(serve_hold), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   // Sample at edge N, outputs observed just after edge N+1.
   task automatic send(input int x, input int y, input int xd, input int yd);
      bx = 6'(x); by = 6'(y); bx_dir = xd[0]; by_dir = yd[0]; pos_valid = 1'b1;
      @(posedge clk); #1 pos_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_play();
      int n = 0;
      while (serve_hold && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("serve_timeout", serve_hold, 0);
   endtask

   // Starting just after the edge that entered SERVE_WAIT (or after reset release).
   task automatic serve_tail(input string tag);
      repeat (31) @(posedge clk);
      #1 chk({tag, "_hold_last"}, serve_hold, 1);
      @(posedge clk); #1 chk({tag, "_hold_fall"}, serve_hold, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("rst_pc", paddle_collision, 0);
      chk("rst_wc", wall_collision, 0);
      chk("rst_ps", point_scored, 0);
      chk("rst_scorer", scorer, 0);
      chk("rst_go", game_over, 0);
      chk("rst_sc1", sc1, 0);
      chk("rst_sc2", sc2, 0);
      chk("rst_hold", serve_hold, 1);
      @(posedge clk); #1 reset = 1'b0;
      serve_tail("rst");

      // Left paddle hit, suppression, re-arm
      p1_y = 6'd20; p2_y = 6'd0;
      send(3, 24, 0, 0);
      chk("lhit_pc", paddle_collision, 1);
      chk("lhit_wc", wall_collision, 0);
      @(posedge clk); #1 chk("lhit_pulse_end", paddle_collision, 0);
      send(3, 24, 0, 0);
      chk("lhit_repeat_pc", paddle_collision, 0);
      send(3, 24, 1, 0);
      chk("lhit_opp_pc", paddle_collision, 0);
      send(3, 24, 0, 0);
      chk("lhit_rearm_pc", paddle_collision, 1);
      send(3, 29, 0, 0);
      chk("lhit_below_pc", paddle_collision, 0);

      // Corner hit: right paddle and bottom wall together
      p2_y = 6'd56;
      send(61, 63, 1, 1);
      chk("corner_pc", paddle_collision, 1);
      chk("corner_wc", wall_collision, 1);

      // Top wall alone, then re-arm top
      send(30, 0, 1, 0);
      chk("top_wc", wall_collision, 1);
      chk("top_pc", paddle_collision, 0);
      send(30, 5, 1, 1);
      chk("idle_wc", wall_collision, 0);

      // Miss at top-left corner: miss overrides the wall hit
      p1_y = 6'd40;
      send(0, 0, 0, 0);
      chk("miss_ps", point_scored, 1);
      chk("miss_scorer", scorer, 1);
      chk("miss_sc2", sc2, 1);
      chk("miss_sc1", sc1, 0);
      chk("miss_pc", paddle_collision, 0);
      chk("miss_wc", wall_collision, 0);
      chk("miss_hold", serve_hold, 1);
      p1_y = 6'd20;
      send(3, 24, 0, 0);
      chk("serve_ignored_pc", paddle_collision, 0);
      chk("serve_ignored_ps", point_scored, 0);
      repeat (29) @(posedge clk);
      #1 chk("miss_hold_last", serve_hold, 1);
      @(posedge clk); #1 chk("miss_hold_fall", serve_hold, 0);

      // Seven player-1 points end the game
      p2_y = 6'd0;
      for (int i = 1; i <= 7; i++) begin
         send(63, 30, 1, 0);
         chk($sformatf("win%0d_ps", i), point_scored, 1);
         chk($sformatf("win%0d_scorer", i), scorer, 0);
         chk($sformatf("win%0d_sc1", i), sc1, i);
         if (i < 7) wait_play();
      end
      chk("win_go", game_over, 1);
      chk("win_hold", serve_hold, 1);
      chk("win_sc2", sc2, 1);
      repeat (40) @(posedge clk);
      send(63, 30, 1, 0);
      chk("go_ignored_ps", point_scored, 0);
      chk("go_still", game_over, 1);
      chk("go_hold", serve_hold, 1);
      chk("go_sc1", sc1, 7);

      // Restart
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("start_sc1", sc1, 0);
      chk("start_sc2", sc2, 0);
      chk("start_go", game_over, 0);
      chk("start_hold", serve_hold, 1);
      serve_tail("start");

      // Reset mid-serve with sc1=3
      for (int i = 1; i <= 3; i++) begin
         send(63, 30, 1, 0);
         chk($sformatf("pre%0d_sc1", i), sc1, i);
         if (i < 3) wait_play();
      end
      repeat (9) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("midrst_sc1", sc1, 0);
      chk("midrst_hold", serve_hold, 1);
      chk("midrst_go", game_over, 0);
      @(posedge clk); #1 reset = 1'b0;
      serve_tail("midrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pong_collision_scorer.md
# pong_collision_scorer

Producer side of the ball-movement interface. Samples the ball position and direction each time the ball updates, checks them against the field walls and both paddles, and returns one-cycle `paddle_collision` / `wall_collision` pulses to the ball mover. It also detects missed balls and keeps both scores (`sc1`, `sc2`). A serve/game-over state machine drives `serve_hold` and `game_over`, which recentre the ball and freeze play.

## Interface
- `COORD_W`, 6: width of all coordinates
- `FIELD_W`, 64: field width; x runs 0..FIELD_W-1
- `FIELD_H`, 64: field height; y runs 0..FIELD_H-1
- `PADDLE_H`, 8: paddle height in pixels
- `LEFT_X`, 2: x of left paddle face
- `RIGHT_X`, 61: x of right paddle face
- `WIN_SCORE`, 7: score that ends the game
- `SERVE_DELAY`, 32: clk cycles `serve_hold` stays high after a point or start
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `pos_valid` in 1: one-cycle strobe; `bx`/`by`/`bx_dir`/`by_dir` are valid this cycle
- `bx`, `by` in COORD_W: ball position
- `bx_dir` in 1: 1 = moving right, 0 = moving left
- `by_dir` in 1: 1 = moving down, 0 = moving up
- `p1_y`, `p2_y` in COORD_W: top row of left paddle / right paddle
- `start` in 1: one-cycle pulse that restarts after game over
- `paddle_collision` out 1: one-cycle pulse; ball mover negates x velocity
- `wall_collision` out 1: one-cycle pulse; ball mover negates y velocity
- `point_scored` out 1: one-cycle pulse when a point is awarded
- `scorer` out 1: 0 = player 1 scored, 1 = player 2; valid with `point_scored`
- `sc1`, `sc2` out 4: scores
- `serve_hold` out 1: high = ball held at centre (31,31)
- `game_over` out 1: high while in GAME_OVER

## Operation
- States:
  - PLAY: normal evaluation of each `pos_valid` sample.
  - SERVE_WAIT: counter runs; `pos_valid` is ignored.
  - GAME_OVER: `pos_valid` is ignored; waits for `start`.
- Paddle range test uses COORD_W+1-bit arithmetic with no wrap: `p_y <= by <= p_y + PADDLE_H - 1`.
- Left paddle hit: `bx_dir`=0, 1 <= `bx` <= LEFT_X+1, `by` in the `p1_y` range, and `left_armed`=1.
- Right paddle hit: `bx_dir`=1, RIGHT_X-1 <= `bx` <= FIELD_W-2, `by` in the `p2_y` range, and `right_armed`=1.
- Miss:
  - `bx_dir`=0 and `bx`=0: player 2 scores.
  - `bx_dir`=1 and `bx`=FIELD_W-1: player 1 scores.
- Wall hit: `top_armed`=1 with `by_dir`=0 and `by`=0, or `bot_armed`=1 with `by_dir`=1 and `by`=FIELD_H-1.
- Arming (suppresses repeat pulses while the ball is still in a zone):
  - A hit clears the matching armed flag.
  - A sample with the opposite direction re-arms it: `bx_dir`=1 re-arms left, `bx_dir`=0 re-arms right, `by_dir`=1 re-arms top, `by_dir`=0 re-arms bottom.
  - All flags are set on reset, on entry to SERVE_WAIT and on `start`.
- Priority within one sample:
  - Miss overrides everything: no collision pulses, `point_scored`=1.
  - Otherwise paddle and wall hits are independent; both pulses may assert together (corner hit).
- PLAY -> SERVE_WAIT on a miss:
  - The scorer's counter increments.
  - If the new value equals WIN_SCORE, go to GAME_OVER instead.
- SERVE_WAIT -> PLAY when the counter reaches SERVE_DELAY-1.
- GAME_OVER -> SERVE_WAIT on `start`; `sc1` and `sc2` clear to 0.
- `start` in PLAY or SERVE_WAIT is ignored.
- Scores never exceed WIN_SCORE, so there is no wrap.

## Timing
- Reset values:
  - State SERVE_WAIT, counter 0, all armed flags 1.
  - `paddle_collision`, `wall_collision`, `point_scored`, `scorer`, `game_over` = 0.
  - `sc1`, `sc2` = 0; `serve_hold` = 1.
- All outputs are registered.
- A `pos_valid` sample at edge N produces pulses high for exactly the cycle after edge N+1.
- `sc1`/`sc2` update in the same cycle as `point_scored`.
- `serve_hold` rises in that same cycle and stays high for exactly SERVE_DELAY cycles, then falls as the state returns to PLAY.
- `game_over` rises in the cycle of the winning `point_scored`; `serve_hold` stays high throughout GAME_OVER.
- `pos_valid` on back-to-back cycles is legal; each sample is evaluated independently.
- Reset mid-serve or mid-game immediately forces the reset values.

## Test plan
- Reset check: assert `reset` asynchronously between edges -> all outputs take their reset values at once; 32 cycles later `serve_hold`=0.
- Left paddle hit with suppression: PLAY, `p1_y`=20; sample (`bx`=3, `by`=24, `bx_dir`=0) -> one `paddle_collision` pulse. Repeat the same sample -> no pulse. Sample with `bx_dir`=1, then `bx_dir`=0 again in the zone -> pulse.
- Corner hit: `p2_y`=56, sample (`bx`=61, `by`=63, `bx_dir`=1, `by_dir`=1) -> `paddle_collision` and `wall_collision` both pulse in the same cycle.
- Miss and serve: sample (`bx`=0, `by`=10, `bx_dir`=0) with the paddle away -> `point_scored`=1, `scorer`=1, `sc2`=1, no collision pulses. `serve_hold` is high for 32 cycles; samples during that window produce nothing.
- Win and restart: seven player-1 misses -> `sc1`=7, `game_over`=1. `pos_valid` samples are ignored until `start`, after which `sc1`=`sc2`=0, `game_over`=0 and SERVE_WAIT runs for 32 cycles.
- Reset mid-serve: assert `reset` 10 cycles into SERVE_WAIT with `sc1`=3 -> `sc1`=0 and the serve counter restarts from 0.
